// File: rtl/csa_acc_pkg.sv
// Shared definitions for csa_accumulator: FSM state encoding and the
// helper that splits the AW-bit carry-propagate add into two halves.
package csa_acc_pkg;

    localparam logic [1:0] ACCUM  = 2'd0;
    localparam logic [1:0] RES_LO = 2'd1;
    localparam logic [1:0] RES_HI = 2'd2;
    localparam logic [1:0] OUT    = 2'd3;

    // Width of each CPA half; AW is expected to be even.
    function automatic int half_width(input int aw);
        return aw / 2;
    endfunction

endpackage

// File: rtl/compressor42.sv
// Bitwise 4:2 compressor: a+b+c+d == sum+carry exactly, both W+1 bits wide.
// Bit W of sum and carry holds the weight that a W-bit accumulator would drop.
module compressor42 #(
    parameter int W = 24
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    input  logic [W-1:0] d,
    output logic [W:0]   sum,
    output logic [W:0]   carry
);

    logic [W-1:0] s1;
    logic [W-1:0] t;
    logic [W-1:0] t_in;
    logic [W-1:0] s2;
    logic [W-1:0] cy;

    // First full-adder row; its carries move sideways one bit without rippling.
    assign s1   = a ^ b ^ c;
    assign t    = (a & b) | (a & c) | (b & c);
    assign t_in = {t[W-2:0], 1'b0};

    assign s2 = s1 ^ d ^ t_in;
    assign cy = (s1 & d) | (s1 & t_in) | (d & t_in);

    assign sum   = {t[W-1], s2};
    assign carry = {cy, 1'b0};

endmodule

// File: rtl/csa_accumulator.sv
// Carry-save accumulator with a two-stage pipelined resolve and valid/ready output.
// Define CSA_ACC_OVF_EN to track the sticky overflow flag; otherwise out_ovf is 0.
module csa_accumulator
    import csa_acc_pkg::*;
#(
    parameter int NN = 16,
    parameter int AW = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [NN:0]   in_sum,
    input  logic [NN:0]   in_carry,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_data,
    output logic          out_ovf
);

    localparam int HW = half_width(AW);

    logic [1:0]    state;
    logic [AW-1:0] acc_s;
    logic [AW-1:0] acc_c;
    logic [HW-1:0] lo_q;
    logic          lo_cy_q;
    logic [AW-1:0] sum_ext;
    logic [AW-1:0] carry_ext;
    logic [AW:0]   cmp_s;
    logic [AW:0]   cmp_c;
    logic [HW:0]   lo_add;
    logic [HW:0]   hi_add;
    logic          accept;
    logic          handshake;

    // Gated by rst so the upstream sees no acceptance while reset is held.
    assign in_ready  = ~rst & (state == ACCUM);
    assign accept    = in_valid & in_ready;
    assign handshake = out_valid & out_ready;

    assign sum_ext   = AW'(in_sum);
    assign carry_ext = AW'(in_carry);

    compressor42 #(.W(AW)) u_cmp (
        .a     (acc_s),
        .b     (acc_c),
        .c     (sum_ext),
        .d     (carry_ext),
        .sum   (cmp_s),
        .carry (cmp_c)
    );

    assign lo_add = {1'b0, acc_s[HW-1:0]} + {1'b0, acc_c[HW-1:0]};
    assign hi_add = {1'b0, acc_s[AW-1:HW]} + {1'b0, acc_c[AW-1:HW]} + {{HW{1'b0}}, lo_cy_q};

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACCUM;
            acc_s     <= '0;
            acc_c     <= '0;
            lo_q      <= '0;
            lo_cy_q   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        acc_s <= cmp_s[AW-1:0];
                        acc_c <= cmp_c[AW-1:0];
                        if (in_last) state <= RES_LO;
                    end
                end
                RES_LO: begin
                    lo_q    <= lo_add[HW-1:0];
                    lo_cy_q <= lo_add[HW];
                    state   <= RES_HI;
                end
                RES_HI: begin
                    out_data <= {hi_add[HW-1:0], lo_q};
                    state    <= OUT;
                end
                OUT: begin
                    // out_valid is itself registered, so it rises one cycle into OUT.
                    if (handshake) begin
                        acc_s     <= '0;
                        acc_c     <= '0;
                        out_valid <= 1'b0;
                        state     <= ACCUM;
                    end else begin
                        out_valid <= 1'b1;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

`ifdef CSA_ACC_OVF_EN
    logic ovf_sticky;
    logic ovf_q;

    // Weight dropped at bit AW on any compression, or the final CPA carry, means sum >= 2^AW.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_sticky <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            if (accept && (cmp_s[AW] || cmp_c[AW])) ovf_sticky <= 1'b1;
            if (state == RES_HI) ovf_q <= ovf_sticky | hi_add[HW];
            if (state == OUT && handshake) ovf_sticky <= 1'b0;
        end
    end

    assign out_ovf = ovf_q;
`else
    logic unused_ovf_taps;
    assign unused_ovf_taps = cmp_s[AW] | cmp_c[AW] | hi_add[HW];
    assign out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_csa_accumulator.sv
// Scoreboard bench for csa_accumulator: exact-integer reference model, a driver
// that pushes expected frame results, and a monitor that pops and compares.
module tb_csa_accumulator;

    localparam int NN = 16;
    localparam int AW = 24;

    typedef struct {
        logic [AW-1:0] data;
        logic          ovf;
        int            acc_cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [NN:0]   in_sum = '0;
    logic [NN:0]   in_carry = '0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [AW-1:0] out_data;
    logic          out_ovf;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    logic [63:0] total = '0;

    csa_accumulator #(.NN(NN), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .in_carry  (in_carry),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait budget expired (cycle %0d)", name, cyc);
    endtask

    // Drives one term, waits for acceptance, updates the model, returns the accept edge.
    task automatic send_term(input logic [NN:0] s, input logic [NN:0] c, input bit last,
                             output int acc_cyc);
        int waited = 0;
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        in_sum   = s;
        in_carry = c;
        in_last  = last;
        while (in_ready !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (in_ready !== 1'b1) begin
            timeout_fail("accept_wait");
            in_valid = 1'b0;
            acc_cyc  = -1;
            return;
        end
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        total   = total + 64'(s) + 64'(c);
        if (last) begin
            in_valid  = 1'b0;
            e.data    = total[AW-1:0];
`ifdef CSA_ACC_OVF_EN
            e.ovf     = (total >= (64'd1 << AW));
`else
            e.ovf     = 1'b0;
`endif
            e.acc_cyc = acc_cyc;
            exp_q.push_back(e);
            total = '0;
        end
    endtask

    task automatic drain();
        int waited = 0;
        while ((exp_q.size() != 0 || out_valid !== 1'b0) && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() != 0 || out_valid !== 1'b0) timeout_fail("drain");
    endtask

    // Monitor: pops on each rising out_valid and checks data/flags every cycle it stays high.
    initial begin
        exp_t cur;
        bit   have = 1'b0;
        bit   prev = 1'b0;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                if (!prev) begin
                    if (exp_q.size() == 0) begin
                        timeout_fail("unexpected_output");
                        have = 1'b0;
                    end else begin
                        cur  = exp_q.pop_front();
                        have = 1'b1;
                        check("latency", 64'(cyc), 64'(cur.acc_cyc + 3));
                    end
                end
                if (have) begin
                    check("out_data", 64'(out_data), 64'(cur.data));
                    check("out_ovf", 64'(out_ovf), 64'(cur.ovf));
                    check("in_ready_in_out", 64'(in_ready), 64'd0);
                end
            end
            prev = (out_valid === 1'b1);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int k0;
        int e;
        int waited;

        // Reset held for two edges; all outputs must read 0.
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_ovf", 64'(out_ovf), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_reset", 64'(in_ready), 64'd1);

        // Single term 5 + 3.
        send_term(17'd5, 17'd3, 1'b1, k);
        drain();

        // Four back-to-back terms of 0x1FFFF pairs.
        send_term(17'h1FFFF, 17'h1FFFF, 1'b0, k0);
        for (int i = 1; i < 4; i++) begin
            send_term(17'h1FFFF, 17'h1FFFF, (i == 3), k);
            check("back_to_back", 64'(k), 64'(k0 + i));
        end
        drain();

        // 130 terms wrap the accumulator twice.
        for (int i = 0; i < 130; i++) send_term(17'h1FFFF, 17'h1FFFF, (i == 129), k);
        drain();

        // Output backpressure for five cycles, then an immediate next frame.
        out_ready = 1'b0;
        send_term(17'($urandom()), 17'($urandom()), 1'b1, k);
        waited = 0;
        while (out_valid !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (out_valid !== 1'b1) timeout_fail("out_valid_wait");
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1;
        e = cyc;
        out_ready = 1'b1;
        send_term(17'd1, 17'd2, 1'b1, k);
        check("next_frame_accept", 64'(k), 64'(e + 2));
        drain();

        // Randomized frames with occasional input bubbles.
        for (int f = 0; f < 20; f++) begin
            int len;
            len = $urandom_range(1, 6);
            for (int t = 0; t < len; t++) begin
                if ($urandom_range(0, 3) == 0) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                end
                send_term(17'($urandom()), 17'($urandom()), (t == len - 1), k);
            end
        end
        drain();

        // Reset while resolving the high half aborts the frame.
        send_term(17'($urandom()), 17'($urandom()), 1'b0, k);
        send_term(17'($urandom()), 17'($urandom()), 1'b1, k);
        @(posedge clk);
        #1 rst = 1'b1;
        void'(exp_q.pop_back());
        @(posedge clk);
        @(negedge clk);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_out_data", 64'(out_data), 64'd0);
        check("abort_out_ovf", 64'(out_ovf), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_state_accum", 64'(in_ready), 64'd1);
        send_term(17'd1, 17'd1, 1'b1, k);
        drain();

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
